// File: rtl/mem_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_param
// Purpose  : Parametrised bridge between the core memory port and a
//            synchronous single-port RAM, plus one memory-mapped IO word.
//            Reads have priority over writes; read data is registered.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, reset             clock / asynchronous active-high reset
//   core_addr/wdata/wmask  core byte address, write data, byte write mask
//   core_rstrb             read request strobe
//   core_rdata             registered read data (held until next read ends)
//   core_rbusy/wbusy       read / write in progress
//   ram_addr/wdata/byteena registered RAM word address, data, byte enables
//   ram_wen/ram_rden       RAM write / read enables (never both high)
//   ram_rdata              RAM read data, valid READ_LAT cycles after rden
//   io_wen/io_wdata        one-cycle IO write strobe and registered data
//   io_rdata               IO read value
//   addr_err               sticky out-of-range flag (MEMCTL_RANGE_CHECK_EN)
// Optional feature macro: MEMCTL_RANGE_CHECK_EN
// ============================================================================
module mem_ctrl_param #(
    parameter int          DATA_W   = 32,
    parameter int          ADDR_W   = 10,
    parameter int          READ_LAT = 1,
    parameter logic [31:0] IO_ADDR  = 32'h0000_0FFC
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           core_addr,
    input  logic [DATA_W-1:0]     core_wdata,
    input  logic [DATA_W/8-1:0]   core_wmask,
    input  logic                  core_rstrb,
    output logic [DATA_W-1:0]     core_rdata,
    output logic                  core_rbusy,
    output logic                  core_wbusy,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    output logic                  ram_wen,
    output logic                  ram_rden,
    output logic [DATA_W/8-1:0]   ram_byteena,
    input  logic [DATA_W-1:0]     ram_rdata,
    output logic                  io_wen,
    output logic [DATA_W-1:0]     io_wdata,
`ifdef MEMCTL_RANGE_CHECK_EN
    output logic                  addr_err,
`endif
    input  logic [DATA_W-1:0]     io_rdata
);

    localparam int         BE_W     = DATA_W / 8;
    localparam logic [2:0] c_lat_m1 = 3'(READ_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD      = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR      = 3'd3,
        S_IO_RD   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   core_rdata_q, core_rdata_d;
    logic                core_rbusy_q, core_rbusy_d;
    logic                core_wbusy_q, core_wbusy_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic                ram_wen_q, ram_wen_d;
    logic                ram_rden_q, ram_rden_d;
    logic [BE_W-1:0]     ram_byteena_q, ram_byteena_d;
    logic                io_wen_q, io_wen_d;
    logic [DATA_W-1:0]   io_wdata_q, io_wdata_d;

    // The IO word is matched on the word address; byte offset is don't-care.
    logic w_is_io;
    logic w_unused_addr;
    assign w_is_io       = (core_addr[31:2] == IO_ADDR[31:2]);
    assign w_unused_addr = ^core_addr[1:0];

`ifdef MEMCTL_RANGE_CHECK_EN
    // A dropped read reuses the one-cycle IO_RD slot and returns zero.
    logic w_hi;
    logic drop_q, drop_d;
    logic addr_err_q, addr_err_d;
    assign w_hi = ((core_addr >> (ADDR_W + 2)) != 32'd0);
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        core_rdata_d  = core_rdata_q;
        ram_addr_d    = ram_addr_q;
        ram_wdata_d   = ram_wdata_q;
        ram_byteena_d = '0;
        io_wen_d      = 1'b0;
        io_wdata_d    = io_wdata_q;
`ifdef MEMCTL_RANGE_CHECK_EN
        drop_d        = drop_q;
        addr_err_d    = addr_err_q;
`endif
        case (state_q)
            S_IDLE: begin
`ifdef MEMCTL_RANGE_CHECK_EN
                drop_d = 1'b0;
`endif
                if (core_rstrb) begin
                    if (w_is_io) begin
                        state_d = S_IO_RD;
`ifdef MEMCTL_RANGE_CHECK_EN
                    end else if (w_hi) begin
                        state_d    = S_IO_RD;
                        drop_d     = 1'b1;
                        addr_err_d = 1'b1;
`endif
                    end else begin
                        state_d    = S_RD;
                        ram_addr_d = core_addr[ADDR_W+1:2];
                        cnt_d      = c_lat_m1;
                    end
                end else if (|core_wmask) begin
                    if (w_is_io) begin
                        io_wen_d   = 1'b1;
                        io_wdata_d = core_wdata;
`ifdef MEMCTL_RANGE_CHECK_EN
                    end else if (w_hi) begin
                        addr_err_d = 1'b1;
`endif
                    end else begin
                        state_d       = S_WR;
                        ram_addr_d    = core_addr[ADDR_W+1:2];
                        ram_wdata_d   = core_wdata;
                        ram_byteena_d = core_wmask;
                    end
                end
            end
            S_RD: begin
                state_d = S_RD_WAIT;
                cnt_d   = c_lat_m1;
            end
            S_RD_WAIT: begin
                // READ_LAT cycles here; RAM data is valid in the last one.
                if (cnt_q == 3'd0) begin
                    core_rdata_d = ram_rdata;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_WR: begin
                state_d = S_IDLE;
            end
            S_IO_RD: begin
`ifdef MEMCTL_RANGE_CHECK_EN
                core_rdata_d = drop_q ? '0 : io_rdata;
`else
                core_rdata_d = io_rdata;
`endif
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered versions of the next state.
        core_rbusy_d = (state_d == S_RD) || (state_d == S_RD_WAIT) || (state_d == S_IO_RD);
        ram_rden_d   = (state_d == S_RD);
        ram_wen_d    = (state_d == S_WR);
        core_wbusy_d = (state_d == S_WR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= 3'd0;
            core_rdata_q  <= '0;
            core_rbusy_q  <= 1'b0;
            core_wbusy_q  <= 1'b0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            ram_wen_q     <= 1'b0;
            ram_rden_q    <= 1'b0;
            ram_byteena_q <= '0;
            io_wen_q      <= 1'b0;
            io_wdata_q    <= '0;
`ifdef MEMCTL_RANGE_CHECK_EN
            drop_q        <= 1'b0;
            addr_err_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            core_rdata_q  <= core_rdata_d;
            core_rbusy_q  <= core_rbusy_d;
            core_wbusy_q  <= core_wbusy_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            ram_wen_q     <= ram_wen_d;
            ram_rden_q    <= ram_rden_d;
            ram_byteena_q <= ram_byteena_d;
            io_wen_q      <= io_wen_d;
            io_wdata_q    <= io_wdata_d;
`ifdef MEMCTL_RANGE_CHECK_EN
            drop_q        <= drop_d;
            addr_err_q    <= addr_err_d;
`endif
        end
    end

    assign core_rdata  = core_rdata_q;
    assign core_rbusy  = core_rbusy_q;
    assign core_wbusy  = core_wbusy_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = ram_wdata_q;
    assign ram_wen     = ram_wen_q;
    assign ram_rden    = ram_rden_q;
    assign ram_byteena = ram_byteena_q;
    assign io_wen      = io_wen_q;
    assign io_wdata    = io_wdata_q;
`ifdef MEMCTL_RANGE_CHECK_EN
    assign addr_err    = addr_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl_param
// Purpose  : Self-checking bench for mem_ctrl_param. Two instances (read
//            latency 1 and 3) see the same core stimulus, each with its own
//            behavioural RAM. Directed vector table, hand sequences for reset
//            and busy corner cases, then random transactions against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl_param;
    localparam int          DW   = 32;
    localparam int          AW   = 10;
    localparam int          BW   = DW / 8;
    localparam logic [31:0] IO_A = 32'h0000_0FFC;
    localparam int          LAT0 = 1;
    localparam int          LAT1 = 3;
`ifdef MEMCTL_RANGE_CHECK_EN
    localparam bit RANGE = 1'b1;
`else
    localparam bit RANGE = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [31:0]   core_addr  = '0;
    logic [DW-1:0] core_wdata = '0;
    logic [BW-1:0] core_wmask = '0;
    logic          core_rstrb = 1'b0;
    logic [DW-1:0] io_rdata   = '0;

    logic [1:0][DW-1:0] rdata, ram_wdata, ram_rdata, io_wdata;
    logic [1:0][AW-1:0] ram_addr;
    logic [1:0][BW-1:0] ram_be;
    logic [1:0]         rbusy, wbusy, ram_wen, ram_rden, io_wen;
`ifdef MEMCTL_RANGE_CHECK_EN
    logic [1:0]         addr_err;
`endif

    mem_ctrl_param #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(LAT0), .IO_ADDR(IO_A)) u_dut0 (
        .clk(clk), .reset(reset), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_wmask(core_wmask), .core_rstrb(core_rstrb), .core_rdata(rdata[0]),
        .core_rbusy(rbusy[0]), .core_wbusy(wbusy[0]), .ram_addr(ram_addr[0]),
        .ram_wdata(ram_wdata[0]), .ram_wen(ram_wen[0]), .ram_rden(ram_rden[0]),
        .ram_byteena(ram_be[0]), .ram_rdata(ram_rdata[0]), .io_wen(io_wen[0]),
        .io_wdata(io_wdata[0]),
`ifdef MEMCTL_RANGE_CHECK_EN
        .addr_err(addr_err[0]),
`endif
        .io_rdata(io_rdata)
    );

    mem_ctrl_param #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(LAT1), .IO_ADDR(IO_A)) u_dut1 (
        .clk(clk), .reset(reset), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_wmask(core_wmask), .core_rstrb(core_rstrb), .core_rdata(rdata[1]),
        .core_rbusy(rbusy[1]), .core_wbusy(wbusy[1]), .ram_addr(ram_addr[1]),
        .ram_wdata(ram_wdata[1]), .ram_wen(ram_wen[1]), .ram_rden(ram_rden[1]),
        .ram_byteena(ram_be[1]), .ram_rdata(ram_rdata[1]), .io_wen(io_wen[1]),
        .io_wdata(io_wdata[1]),
`ifdef MEMCTL_RANGE_CHECK_EN
        .addr_err(addr_err[1]),
`endif
        .io_rdata(io_rdata)
    );

    // Behavioural synchronous RAM with byte enables and L-cycle read latency.
    for (genvar gi = 0; gi < 2; gi++) begin : g_ram
        localparam int L = (gi == 0) ? LAT0 : LAT1;
        logic [DW-1:0] mem [1<<AW];
        logic [DW-1:0] pipe [L];
        initial for (int k = 0; k < (1 << AW); k++) mem[k] = '0;
        always @(posedge clk) begin
            if (ram_rden[gi]) pipe[0] <= mem[ram_addr[gi]];
            for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
            if (ram_wen[gi])
                for (int b = 0; b < BW; b++)
                    if (ram_be[gi][b]) mem[ram_addr[gi]][8*b +: 8] = ram_wdata[gi][8*b +: 8];
        end
        assign ram_rdata[gi] = pipe[L-1];
    end

    // Cumulative activity counters, sampled at the active edge.
    int cnt_rb[2], cnt_wb[2], cnt_rd[2], cnt_wn[2], cnt_io[2], cnt_bad[2];
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            cnt_rb[i]  <= cnt_rb[i] + int'(rbusy[i]);
            cnt_wb[i]  <= cnt_wb[i] + int'(wbusy[i]);
            cnt_rd[i]  <= cnt_rd[i] + int'(ram_rden[i]);
            cnt_wn[i]  <= cnt_wn[i] + int'(ram_wen[i]);
            cnt_io[i]  <= cnt_io[i] + int'(io_wen[i]);
            cnt_bad[i] <= cnt_bad[i] + int'((ram_wen[i] & ram_rden[i]) | (io_wen[i] & ram_wen[i]));
        end
    end

    int n_chk = 0;
    int n_pass = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    int b_rb[2], b_wb[2], b_rd[2], b_wn[2], b_io[2], b_bad[2];
    int d_rb[2], d_wb[2], d_rd[2], d_wn[2], d_io[2], d_bad[2];
    logic [1:0][AW-1:0] s_addr;
    logic [1:0][BW-1:0] s_be;
    logic [1:0][DW-1:0] s_wd, s_iowd;

    task automatic snap();
        for (int i = 0; i < 2; i++) begin
            b_rb[i] = cnt_rb[i]; b_wb[i] = cnt_wb[i]; b_rd[i] = cnt_rd[i];
            b_wn[i] = cnt_wn[i]; b_io[i] = cnt_io[i]; b_bad[i] = cnt_bad[i];
        end
    endtask

    task automatic delta();
        for (int i = 0; i < 2; i++) begin
            d_rb[i] = cnt_rb[i] - b_rb[i]; d_wb[i] = cnt_wb[i] - b_wb[i];
            d_rd[i] = cnt_rd[i] - b_rd[i]; d_wn[i] = cnt_wn[i] - b_wn[i];
            d_io[i] = cnt_io[i] - b_io[i]; d_bad[i] = cnt_bad[i] - b_bad[i];
        end
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((rbusy != 2'b00 || wbusy != 2'b00) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) chk("busy_timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    // One request presented for exactly one accept edge, then run to idle.
    task automatic txn(input logic [31:0] a, input logic [DW-1:0] wd,
                       input logic [BW-1:0] m, input logic rs, input logic [DW-1:0] io);
        @(negedge clk);
        snap();
        core_addr = a; core_wdata = wd; core_wmask = m; core_rstrb = rs; io_rdata = io;
        @(negedge clk);
        s_addr = ram_addr; s_be = ram_be; s_wd = ram_wdata; s_iowd = io_wdata;
        core_rstrb = 1'b0; core_wmask = '0;
        wait_idle();
        delta();
    endtask

    task automatic check_txn(input string tag, input logic [31:0] a, input logic [DW-1:0] wd,
                             input logic [BW-1:0] m, input logic [DW-1:0] erd,
                             input int rb0, input int rb1, input bit rden, input bit wen, input bit iow);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s u%0d rdata", tag, i), rdata[i], erd);
            chk($sformatf("%s u%0d rbusy_cycles", tag, i), 32'(d_rb[i]), 32'((i == 0) ? rb0 : rb1));
            chk($sformatf("%s u%0d wbusy_cycles", tag, i), 32'(d_wb[i]), 32'(wen));
            chk($sformatf("%s u%0d rden_cycles", tag, i), 32'(d_rd[i]), 32'(rden));
            chk($sformatf("%s u%0d wen_cycles", tag, i), 32'(d_wn[i]), 32'(wen));
            chk($sformatf("%s u%0d iowen_cycles", tag, i), 32'(d_io[i]), 32'(iow));
            chk($sformatf("%s u%0d enable_overlap", tag, i), 32'(d_bad[i]), 32'd0);
            chk($sformatf("%s u%0d byteena_idle", tag, i), 32'(ram_be[i]), 32'd0);
            if (wen) begin
                chk($sformatf("%s u%0d wr_addr", tag, i), 32'(s_addr[i]), 32'(a[AW+1:2]));
                chk($sformatf("%s u%0d wr_be", tag, i), 32'(s_be[i]), 32'(m));
                chk($sformatf("%s u%0d wr_data", tag, i), s_wd[i], wd);
            end
            if (iow) chk($sformatf("%s u%0d io_wdata", tag, i), s_iowd[i], wd);
        end
    endtask

    // Transaction-level reference: expected memory image and read data.
    logic [DW-1:0] ref_mem [1<<AW];
    logic [DW-1:0] ref_rdata = '0;
    task automatic model(input logic [31:0] a, input logic [DW-1:0] wd, input logic [BW-1:0] m,
                         input logic rs, input logic [DW-1:0] io, output int rb0, output int rb1,
                         output bit rden, output bit wen, output bit iow);
        bit is_io = ((a & ~32'h3) == IO_A);
        bit hi    = (a >= (32'd1 << (AW + 2)));
        int w     = int'((a >> 2) % (1 << AW));
        rb0 = 0; rb1 = 0; rden = 0; wen = 0; iow = 0;
        if (rs) begin
            if (is_io) begin
                ref_rdata = io; rb0 = 1; rb1 = 1;
            end else if (RANGE && hi) begin
                ref_rdata = '0; rb0 = 1; rb1 = 1;
            end else begin
                ref_rdata = ref_mem[w]; rb0 = LAT0 + 1; rb1 = LAT1 + 1; rden = 1;
            end
        end else if (m != '0) begin
            if (is_io) iow = 1;
            else if (!(RANGE && hi)) begin
                wen = 1;
                for (int b = 0; b < BW; b++) if (m[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
            end
        end
    endtask

    typedef struct {
        logic [31:0]   a;
        logic [DW-1:0] wd;
        logic [BW-1:0] m;
        logic          rs;
        logic [DW-1:0] io;
        logic [DW-1:0] erd;
        int            rb0;
        int            rb1;
        bit            rden;
        bit            wen;
        bit            iow;
    } vec_t;

    localparam int NV = 16;
    vec_t vt [NV];

    initial begin
        int rb0, rb1;
        bit rden, wen, iow;
        logic [31:0] a;
        logic [DW-1:0] wd, io;
        logic [BW-1:0] m;
        logic rs;

        for (int k = 0; k < (1 << AW); k++) ref_mem[k] = '0;
        //           addr          wdata         mask     rs    io_rdata      exp rdata    rb0 rb1 rden wen iow
        vt[0]  = '{32'h10,      32'hDEADBEEF, 4'hF,    1'b0, 32'h0,        32'h0,        0, 0, 0, 1, 0};
        vt[1]  = '{32'h10,      32'h0,        4'h0,    1'b1, 32'h0,        32'hDEADBEEF, 2, 4, 1, 0, 0};
        vt[2]  = '{32'h20,      32'h12345678, 4'hF,    1'b0, 32'h0,        32'hDEADBEEF, 0, 0, 0, 1, 0};
        vt[3]  = '{32'h20,      32'h0,        4'h0,    1'b1, 32'h0,        32'h12345678, 2, 4, 1, 0, 0};
        vt[4]  = '{32'h24,      32'hCAFEF00D, 4'hF,    1'b0, 32'h0,        32'h12345678, 0, 0, 0, 1, 0};
        vt[5]  = '{32'h8,       32'hAABBCCDD, 4'b0100, 1'b0, 32'h0,        32'h12345678, 0, 0, 0, 1, 0};
        vt[6]  = '{32'h8,       32'h0,        4'h0,    1'b1, 32'h0,        32'h00BB0000, 2, 4, 1, 0, 0};
        vt[7]  = '{32'hFFC,     32'h000000A5, 4'hF,    1'b0, 32'h0,        32'h00BB0000, 0, 0, 0, 0, 1};
        vt[8]  = '{32'hFFC,     32'h0,        4'h0,    1'b1, 32'h5A,       32'h0000005A, 1, 1, 0, 0, 0};
        vt[9]  = '{32'h10,      32'h11111111, 4'hF,    1'b1, 32'h0,        32'hDEADBEEF, 2, 4, 1, 0, 0};
        vt[10] = '{32'h24,      32'h0,        4'h0,    1'b1, 32'h0,        32'hCAFEF00D, 2, 4, 1, 0, 0};
        vt[11] = '{32'h13,      32'h0,        4'h0,    1'b1, 32'h0,        32'hDEADBEEF, 2, 4, 1, 0, 0};
        vt[12] = '{32'h10,      32'h99999999, 4'h0,    1'b0, 32'h0,        32'hDEADBEEF, 0, 0, 0, 0, 0};
`ifdef MEMCTL_RANGE_CHECK_EN
        vt[13] = '{32'h2010,    32'h0,        4'h0,    1'b1, 32'h0,        32'h0,        1, 1, 0, 0, 0};
        vt[14] = '{32'hFFD,     32'h00000077, 4'b0001, 1'b0, 32'h0,        32'h0,        0, 0, 0, 0, 1};
`else
        vt[13] = '{32'h2010,    32'h0,        4'h0,    1'b1, 32'h0,        32'hDEADBEEF, 2, 4, 1, 0, 0};
        vt[14] = '{32'hFFD,     32'h00000077, 4'b0001, 1'b0, 32'h0,        32'hDEADBEEF, 0, 0, 0, 0, 1};
`endif
        vt[15] = '{32'h24,      32'h0,        4'h0,    1'b1, 32'h0,        32'hCAFEF00D, 2, 4, 1, 0, 0};

        // Reset state.
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset u%0d rdata", i), rdata[i], 32'h0);
            chk($sformatf("reset u%0d ram_addr", i), 32'(ram_addr[i]), 32'h0);
            chk($sformatf("reset u%0d ram_wdata", i), ram_wdata[i], 32'h0);
            chk($sformatf("reset u%0d byteena", i), 32'(ram_be[i]), 32'h0);
            chk($sformatf("reset u%0d io_wdata", i), io_wdata[i], 32'h0);
            chk($sformatf("reset u%0d ctl", i),
                32'({rbusy[i], wbusy[i], ram_wen[i], ram_rden[i], io_wen[i]}), 32'h0);
        end
        reset = 1'b0;
        @(negedge clk);

        // Directed vector table.
        for (int v = 0; v < NV; v++) begin
            txn(vt[v].a, vt[v].wd, vt[v].m, vt[v].rs, vt[v].io);
            model(vt[v].a, vt[v].wd, vt[v].m, vt[v].rs, vt[v].io, rb0, rb1, rden, wen, iow);
            check_txn($sformatf("vec%0d", v), vt[v].a, vt[v].wd, vt[v].m, vt[v].erd,
                      vt[v].rb0, vt[v].rb1, vt[v].rden, vt[v].wen, vt[v].iow);
        end

        // A write presented while a read is in progress is dropped.
        @(negedge clk);
        snap();
        core_addr = 32'h24; core_rstrb = 1'b1; core_wmask = '0;
        @(negedge clk);
        core_rstrb = 1'b0; core_wdata = 32'h0; core_wmask = 4'hF;
        @(negedge clk);
        core_wmask = '0;
        wait_idle();
        delta();
        model(32'h24, 32'h0, 4'h0, 1'b1, 32'h0, rb0, rb1, rden, wen, iow);
        check_txn("busy_ignore", 32'h24, 32'h0, 4'h0, 32'hCAFEF00D, 2, 4, 1, 0, 0);
        txn(32'h24, 32'h0, 4'h0, 1'b1, 32'h0);
        check_txn("busy_ignore_reread", 32'h24, 32'h0, 4'h0, 32'hCAFEF00D, 2, 4, 1, 0, 0);

`ifdef MEMCTL_RANGE_CHECK_EN
        for (int i = 0; i < 2; i++) chk($sformatf("addr_err sticky u%0d", i), 32'(addr_err[i]), 32'd1);
`endif

        // Reset asserted while both instances sit in RD_WAIT.
        @(negedge clk);
        core_addr = 32'h10; core_rstrb = 1'b1;
        @(negedge clk);
        core_rstrb = 1'b0;
        @(negedge clk);
        chk("pre_reset rbusy", 32'(rbusy), 32'h3);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("midreset u%0d rdata", i), rdata[i], 32'h0);
            chk($sformatf("midreset u%0d ram_addr", i), 32'(ram_addr[i]), 32'h0);
            chk($sformatf("midreset u%0d ram_wdata", i), ram_wdata[i], 32'h0);
            chk($sformatf("midreset u%0d io_wdata", i), io_wdata[i], 32'h0);
            chk($sformatf("midreset u%0d ctl", i),
                32'({rbusy[i], wbusy[i], ram_wen[i], ram_rden[i], io_wen[i], ram_be[i]}), 32'h0);
`ifdef MEMCTL_RANGE_CHECK_EN
            chk($sformatf("midreset u%0d addr_err", i), 32'(addr_err[i]), 32'd0);
`endif
        end
        @(negedge clk);
        reset = 1'b0;
        ref_rdata = '0;
        txn(32'h10, 32'h0, 4'h0, 1'b1, 32'h0);
        model(32'h10, 32'h0, 4'h0, 1'b1, 32'h0, rb0, rb1, rden, wen, iow);
        check_txn("after_reset_read", 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 2, 4, 1, 0, 0);

        // Random transactions against the reference model.
        for (int t = 0; t < 200; t++) begin
            int sel = $urandom_range(0, 9);
            if (sel == 0)      a = IO_A | 32'($urandom_range(0, 3));
            else if (sel == 1) a = (32'($urandom_range(1, 15)) << 12) | 32'($urandom_range(0, 255));
            else               a = 32'($urandom_range(0, 63));
            rs = 1'($urandom_range(0, 1));
            m  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            wd = $urandom;
            io = $urandom;
            txn(a, wd, m, rs, io);
            model(a, wd, m, rs, io, rb0, rb1, rden, wen, iow);
            check_txn($sformatf("rnd%0d", t), a, wd, m, ref_rdata, rb0, rb1, rden, wen, iow);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
